// File: rtl/bar_level_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bar_level_encoder_pkg
//  Purpose  : Shared types and constants for the bar display path
//  Revision : 1.0 - initial release
// ============================================================================
package bar_level_encoder_pkg;

  // Fill level in half-bar units, 0..LEVEL_MAX
  typedef logic [3:0] half_level_t;

  // Highest fill level; seven whole bars
  localparam half_level_t LEVEL_MAX = 4'd14;

  // Coarse fill state driving the empty/full flags
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } bar_state_t;

endpackage : bar_level_encoder_pkg
`default_nettype wire

// File: rtl/bar_level_encoder_blink_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : blink_prescaler
//  Purpose  : Divides clk into a blink phase bit of BLINK_DIV cycles per
//             half-period; restart forces a fresh high half-period
//  Revision : 1.0 - initial release
// ============================================================================
module blink_prescaler #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam int           CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running divider; a restart beats a wrap landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule : blink_prescaler
`default_nettype wire

// File: rtl/bar_level_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : bar_level_encoder
//  Purpose  : Tracks a half-bar fill level from inc/dec pulses and produces
//             the count/blink pair for the 7-row bar decoder
//  Revision : 1.0 - initial release
// ============================================================================
module bar_level_encoder
  import bar_level_encoder_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       blink,
  output logic       full,
  output logic       empty,
  output logic       changed
);

  half_level_t level;
  bar_state_t  state;
  logic        phase;
  logic        inc_eff;
  logic        dec_eff;
  logic        move;

  // A pulse only counts when exactly one input is high and it is not
  // pushing past either end of the range
  assign inc_eff = inc & ~dec & (level != LEVEL_MAX);
  assign dec_eff = dec & ~inc & (level != 4'd0);
  assign move    = inc_eff | dec_eff;

  // Level register and its one-cycle change strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      changed <= 1'b0;
    end else begin
      changed <= move;
      if (inc_eff)      level <= level + 4'd1;
      else if (dec_eff) level <= level - 4'd1;
    end
  end

  // Coarse fill state with registered empty/full flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (inc_eff) begin
            state <= PARTIAL;
            empty <= 1'b0;
          end
        end
        PARTIAL: begin
          if (inc_eff && level == LEVEL_MAX - 4'd1) begin
            state <= FULL;
            full  <= 1'b1;
          end else if (dec_eff && level == 4'd1) begin
            state <= EMPTY;
            empty <= 1'b1;
          end
        end
        FULL: begin
          if (dec_eff) begin
            state <= PARTIAL;
            full  <= 1'b0;
          end
        end
        default: begin
          state <= EMPTY;
          empty <= 1'b1;
          full  <= 1'b0;
        end
      endcase
    end
  end

  // Any real level move restarts the blink so a new half bar shows at once
  blink_prescaler #(
    .BLINK_DIV (BLINK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (move),
    .phase   (phase)
  );

  assign count = level[3:1];
  assign blink = level[0] & phase;

endmodule : bar_level_encoder
`default_nettype wire

// File: tb/tb_bar_level_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bar_level_encoder
//  Purpose  : Directed self-checking bench for bar_level_encoder, BLINK_DIV=4
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bar_level_encoder;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       dec;
  logic [2:0] count;
  logic       blink;
  logic       full;
  logic       empty;
  logic       changed;

  int errors = 0;
  int checks = 0;

  bar_level_encoder #(
    .BLINK_DIV (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inc     (inc),
    .dec     (dec),
    .count   (count),
    .blink   (blink),
    .full    (full),
    .empty   (empty),
    .changed (changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full output vector comparison
  task automatic chk_all(input string tag, input int c, input int b, input int f,
                         input int e, input int ch);
    chk({tag, ".count"},   {5'd0, count},   8'(c));
    chk({tag, ".blink"},   {7'd0, blink},   8'(b));
    chk({tag, ".full"},    {7'd0, full},    8'(f));
    chk({tag, ".empty"},   {7'd0, empty},   8'(e));
    chk({tag, ".changed"}, {7'd0, changed}, 8'(ch));
  endtask

  task automatic do_reset();
    rst = 1'b1; inc = 1'b0; dec = 1'b0;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; inc = 1'b0; dec = 1'b0;
    tick(1);

    // ---- Reset with inc held: reset wins
    rst = 1'b1; inc = 1'b1;
    tick(1);
    chk_all("reset", 0, 0, 0, 1, 0);

    // ---- Three inc pulses, then blink cadence at level 3
    rst = 1'b0; inc = 1'b1;
    tick(1); chk_all("inc1", 0, 1, 0, 0, 1);
    tick(1); chk_all("inc2", 1, 0, 0, 0, 1);
    tick(1); chk_all("inc3", 1, 1, 0, 0, 1);
    inc = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(1); chk("cad_hi", {7'd0, blink}, 8'd1); end
    tick(1); chk("cad_changed_idle", {7'd0, changed}, 8'd0);
    chk("cad_lo0", {7'd0, blink}, 8'd0);
    for (int i = 0; i < 3; i++) begin tick(1); chk("cad_lo", {7'd0, blink}, 8'd0); end
    tick(1); chk("cad_hi2", {7'd0, blink}, 8'd1);

    // ---- Saturation high: 16 inc pulses
    do_reset();
    inc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      chk("sat_changed", {7'd0, changed}, (i <= 14) ? 8'd1 : 8'd0);
      chk("sat_count",   {5'd0, count},   8'(((i < 14) ? i : 14) / 2));
      chk("sat_full",    {7'd0, full},    (i >= 14) ? 8'd1 : 8'd0);
    end
    inc = 1'b0;
    tick(1); chk_all("at_max", 7, 0, 1, 0, 0);
    dec = 1'b1;
    tick(1); chk_all("dec_from_max", 6, 1, 0, 0, 1);
    dec = 1'b0;

    // ---- Saturation low and simultaneous inputs
    do_reset();
    dec = 1'b1;
    tick(1); chk_all("dec_at_zero", 0, 0, 0, 1, 0);
    dec = 1'b0; inc = 1'b1;
    tick(5); chk_all("level5", 2, 1, 0, 0, 1);
    dec = 1'b1;
    tick(1); chk_all("both_inputs", 2, 1, 0, 0, 0);
    inc = 1'b0; dec = 1'b0;
    tick(1); chk("both_cad1", {7'd0, blink}, 8'd1);
    tick(1); chk("both_cad2", {7'd0, blink}, 8'd1);
    tick(1); chk("both_cad3", {7'd0, blink}, 8'd0);

    // ---- Restart priority: change lands on the prescaler wrap cycle
    do_reset();
    inc = 1'b1;
    tick(4); chk_all("level4", 2, 0, 0, 0, 1);
    inc = 1'b0;
    tick(3);
    inc = 1'b1;
    tick(1); chk_all("wrap_inc", 2, 1, 0, 0, 1);
    inc = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(1); chk("wrap_hi", {7'd0, blink}, 8'd1); end
    tick(1); chk("wrap_lo", {7'd0, blink}, 8'd0);

    // ---- Reset mid-operation with inc
    do_reset();
    inc = 1'b1;
    tick(9); chk_all("level9", 4, 1, 0, 0, 1);
    rst = 1'b1;
    tick(1); chk_all("mid_reset", 0, 0, 0, 1, 0);
    rst = 1'b0; inc = 1'b0;
    tick(1); chk_all("post_reset", 0, 0, 0, 1, 0);

    // ---- Decoder cross-check: lit rows = count + blink
    do_reset();
    for (int lvl = 1; lvl <= 14; lvl++) begin
      inc = 1'b1;
      tick(1);
      inc = 1'b0;
      chk("dec_lit_ph1", 8'(count) + 8'(blink), 8'((lvl + 1) / 2));
      chk("dec_empty",   {7'd0, empty}, 8'd0);
      chk("dec_full",    {7'd0, full},  (lvl == 14) ? 8'd1 : 8'd0);
      tick(4);
      chk("dec_lit_ph0", 8'(count) + 8'(blink), 8'(lvl / 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bar_level_encoder
`default_nettype wire
